// File: rtl/beetle_position_update.sv
// Beetle antenna search position/step sequencer for the fixed-point BAS datapath.
// Optional STEP_FLOOR_EN clamps the decayed step at STEP_MIN.
//   state | meaning
//   IDLE  | waiting for first start
//   SENSE | probes driven, waiting for antenna fitness
//   MOVE  | one-cycle position update and step decay
//   DONE  | MAX_ITER iterations complete, results held
module beetle_position_update #(
  parameter int MAX_ITER    = 64,
  parameter int ITER_W      = 8,
  parameter int ETA_SHIFT   = 3,
  parameter int SENSE_SHIFT = 1
`ifdef STEP_FLOOR_EN
  , parameter int STEP_MIN  = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [15:0]       x_init,
  input  logic signed [15:0]       y_init,
  input  logic signed [13:0]       step_init,
  input  logic signed [8:0]        dir_x,
  input  logic signed [8:0]        dir_y,
  input  logic signed [15:0]       f_l,
  input  logic signed [15:0]       f_r,
  input  logic                     fit_valid,
  output logic signed [15:0]       x,
  output logic signed [15:0]       y,
  output logic signed [13:0]       sense,
  output logic                     req_valid,
  output logic                     busy,
  output logic                     done,
  output logic [ITER_W-1:0]        iter_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SENSE, S_MOVE, S_DONE} state_t;

  state_t state_q, state_d;
  logic signed [15:0] x_q, x_d, y_q, y_d;
  logic signed [13:0] step_q, step_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic signed [15:0] fl_q, fl_d, fr_q, fr_d;
  logic signed [8:0]  dirx_q, dirx_d, diry_q, diry_d;
  logic               req_valid_q, req_valid_d, busy_q, busy_d, done_q, done_d;

  logic signed [22:0] prod_x, prod_y, delta_x, delta_y, sum_x, sum_y;
  logic signed [13:0] step_dec;
  logic [ITER_W-1:0]  iter_inc;

  // Full-width sums make the saturation check exact without extra guard bits.
  function automatic logic signed [15:0] sat16(input logic signed [22:0] v);
    if (v > 23'sd32767)       return 16'sh7fff;
    else if (v < -23'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  always_comb begin
    prod_x  = dirx_q * step_q;
    prod_y  = diry_q * step_q;
    delta_x = prod_x >>> 8;
    delta_y = prod_y >>> 8;
    if (fl_q < fr_q) begin
      sum_x = 23'(x_q) + delta_x;
      sum_y = 23'(y_q) + delta_y;
    end else if (fl_q > fr_q) begin
      sum_x = 23'(x_q) - delta_x;
      sum_y = 23'(y_q) - delta_y;
    end else begin
      sum_x = 23'(x_q);
      sum_y = 23'(y_q);
    end
    step_dec = step_q - (step_q >>> ETA_SHIFT);
`ifdef STEP_FLOOR_EN
    if (step_dec < 14'(STEP_MIN)) step_dec = 14'(STEP_MIN);
`endif
    iter_inc = iter_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    step_d  = step_q;
    iter_d  = iter_q;
    fl_d    = fl_q;
    fr_d    = fr_q;
    dirx_d  = dirx_q;
    diry_d  = diry_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d     = x_init;
          y_d     = y_init;
          step_d  = step_init;
          iter_d  = '0;
          state_d = S_SENSE;
        end
      end
      S_SENSE: begin
        if (fit_valid) begin
          fl_d    = f_l;
          fr_d    = f_r;
          dirx_d  = dir_x;
          diry_d  = dir_y;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        x_d     = sat16(sum_x);
        y_d     = sat16(sum_y);
        step_d  = step_dec;
        iter_d  = iter_inc;
        state_d = (iter_inc == ITER_W'(MAX_ITER)) ? S_DONE : S_SENSE;
      end
      default: state_d = S_IDLE;
    endcase
    req_valid_d = (state_d == S_SENSE);
    busy_d      = (state_d == S_SENSE) || (state_d == S_MOVE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      step_q      <= '0;
      iter_q      <= '0;
      fl_q        <= '0;
      fr_q        <= '0;
      dirx_q      <= '0;
      diry_q      <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      step_q      <= step_d;
      iter_q      <= iter_d;
      fl_q        <= fl_d;
      fr_q        <= fr_d;
      dirx_q      <= dirx_d;
      diry_q      <= diry_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign sense     = step_q >>> SENSE_SHIFT;
  assign req_valid = req_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign iter_cnt  = iter_q;

endmodule
